// File: rtl/lcd_delay_timer.sv
// Tick-based delay timer for the HD44780 sequencer: prescaled countdown with
// retrigger, abort, periodic auto-reload, busy flag and remaining-tick output.
module lcd_delay_timer #(
    parameter int SYSFREQ    = 48_000_000,
    parameter int TICK_HZ    = 1_000_000,
    parameter int COUNT_BITS = 17,
    localparam int DIV_RAW   = SYSFREQ / TICK_HZ,
    localparam int DIV       = (DIV_RAW == 0) ? 1 : DIV_RAW,
    localparam int DIV_BITS  = $clog2(DIV) + 1
) (
    input  logic                  CLK_I,
    input  logic                  RST_I,
    input  logic [COUNT_BITS-1:0] DAT_I,
    input  logic                  start_strobe,
    input  logic                  abort_strobe,
    input  logic                  periodic,
    output logic                  end_strobe,
    output logic                  busy,
    output logic [COUNT_BITS-1:0] count_o
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [DIV_BITS-1:0]   PRESC_LAST = DIV_BITS'(DIV - 1);
    localparam logic [COUNT_BITS-1:0] CNT_ONE    = COUNT_BITS'(1);

    state_t                  state_q, state_d;
    logic [DIV_BITS-1:0]     presc_q, presc_d;
    logic [COUNT_BITS-1:0]   count_q, count_d;
    logic [COUNT_BITS-1:0]   reload_q, reload_d;
    logic                    mode_q, mode_d;
    logic                    end_q, end_d;
    logic                    busy_q, busy_d;

    always_comb begin
        // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
        state_d  = state_q;
        presc_d  = presc_q;
        count_d  = count_q;
        reload_d = reload_q;
        mode_d   = mode_q;
        busy_d   = busy_q;
        end_d    = 1'b0;

        if (abort_strobe) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            count_d = '0;
            presc_d = '0;
        end else if (start_strobe) begin
            presc_d = '0;
            if (DAT_I == '0) begin
                // Zero delay expires on the start edge itself, even in periodic mode.
                end_d   = 1'b1;
                state_d = IDLE;
                busy_d  = 1'b0;
                count_d = '0;
            end else begin
                state_d  = RUN;
                busy_d   = 1'b1;
                count_d  = DAT_I;
                reload_d = DAT_I;
                mode_d   = periodic;
            end
        end else if (state_q == RUN) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = '0;
                if (count_q == CNT_ONE) begin
                    end_d = 1'b1;
                    if (mode_q) begin
                        count_d = reload_q;
                    end else begin
                        count_d = '0;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end else begin
                    count_d = count_q - CNT_ONE;
                end
            end else begin
                presc_d = presc_q + DIV_BITS'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state_q  <= IDLE;
            presc_q  <= '0;
            count_q  <= '0;
            reload_q <= '0;
            mode_q   <= 1'b0;
            end_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            mode_q   <= mode_d;
            end_q    <= end_d;
            busy_q   <= busy_d;
        end
    end

    assign end_strobe = end_q;
    assign busy       = busy_q;
    assign count_o    = count_q;

endmodule

// File: tb/tb_lcd_delay_timer.sv
// Directed bench for lcd_delay_timer: DIV=4 vector table, DIV=1 and DIV=48
// instances, plus hand sequences for reset, retrigger limits and long delays.
module tb_lcd_delay_timer;

    logic CLK_I = 1'b0;
    logic RST_I = 1'b0;
    always #5 CLK_I = ~CLK_I;

    int errors = 0;
    int checks = 0;

    // DIV = 4 instance
    logic        s4_start = 0, s4_abort = 0, s4_per = 0;
    logic [16:0] s4_dat = '0;
    logic        u4_end, u4_busy;
    logic [16:0] u4_cnt;

    // DIV forced to 1 (TICK_HZ above SYSFREQ)
    logic        s1_start = 0, s1_abort = 0, s1_per = 0;
    logic [16:0] s1_dat = '0;
    logic        u1_end, u1_busy;
    logic [16:0] u1_cnt;

    // Default 48 MHz / 1 MHz instance
    logic        s48_start = 0, s48_abort = 0, s48_per = 0;
    logic [16:0] s48_dat = '0;
    logic        u48_end, u48_busy;
    logic [16:0] u48_cnt;

    lcd_delay_timer #(.SYSFREQ(4_000_000), .TICK_HZ(1_000_000)) u4 (
        .CLK_I(CLK_I), .RST_I(RST_I), .DAT_I(s4_dat),
        .start_strobe(s4_start), .abort_strobe(s4_abort), .periodic(s4_per),
        .end_strobe(u4_end), .busy(u4_busy), .count_o(u4_cnt)
    );

    lcd_delay_timer #(.SYSFREQ(1_000_000), .TICK_HZ(2_000_000)) u1 (
        .CLK_I(CLK_I), .RST_I(RST_I), .DAT_I(s1_dat),
        .start_strobe(s1_start), .abort_strobe(s1_abort), .periodic(s1_per),
        .end_strobe(u1_end), .busy(u1_busy), .count_o(u1_cnt)
    );

    lcd_delay_timer u48 (
        .CLK_I(CLK_I), .RST_I(RST_I), .DAT_I(s48_dat),
        .start_strobe(s48_start), .abort_strobe(s48_abort), .periodic(s48_per),
        .end_strobe(u48_end), .busy(u48_busy), .count_o(u48_cnt)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Each step drives inputs at the falling edge, then samples 1 ns after the rising edge.
    task automatic step4(input logic st, input logic ab, input logic per, input logic [16:0] dat);
        @(negedge CLK_I);
        s4_start = st; s4_abort = ab; s4_per = per; s4_dat = dat;
        @(posedge CLK_I);
        #1;
    endtask

    task automatic step1(input logic st, input logic [16:0] dat);
        @(negedge CLK_I);
        s1_start = st; s1_dat = dat;
        @(posedge CLK_I);
        #1;
    endtask

    task automatic step48(input logic st, input logic ab, input logic [16:0] dat);
        @(negedge CLK_I);
        s48_start = st; s48_abort = ab; s48_dat = dat;
        @(posedge CLK_I);
        #1;
    endtask

    typedef struct {
        logic        st;
        logic        ab;
        logic        per;
        logic [16:0] dat;
        int          reps;   // strobes apply on the first cycle only
        logic        e_end;
        logic        e_busy;
        logic [16:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int n;
        logic quiet;

        // One-shot N=3: expiry at E0+12
        vecs.push_back('{1'b1, 1'b0, 1'b0, 17'd3, 1, 1'b0, 1'b1, 17'd3});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 17'd0, 3, 1'b0, 1'b1, 17'd3});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 17'd0, 4, 1'b0, 1'b1, 17'd2});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 17'd0, 4, 1'b0, 1'b1, 17'd1});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 17'd0, 1, 1'b1, 1'b0, 17'd0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 17'd0, 3, 1'b0, 1'b0, 17'd0});
        // Periodic N=2: pulses at E0+8, E0+16; abort at E0+20 kills E0+24
        vecs.push_back('{1'b1, 1'b0, 1'b1, 17'd2, 1, 1'b0, 1'b1, 17'd2});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 17'd0, 3, 1'b0, 1'b1, 17'd2});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 17'd0, 4, 1'b0, 1'b1, 17'd1});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 17'd0, 1, 1'b1, 1'b1, 17'd2});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 17'd0, 3, 1'b0, 1'b1, 17'd2});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 17'd0, 4, 1'b0, 1'b1, 17'd1});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 17'd0, 1, 1'b1, 1'b1, 17'd2});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 17'd0, 3, 1'b0, 1'b1, 17'd2});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 17'd0, 1, 1'b0, 1'b0, 17'd0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 17'd0, 8, 1'b0, 1'b0, 17'd0});
        // N=5 retriggered at E0+10 with N=1: single pulse at E0+14, none at E0+20
        vecs.push_back('{1'b1, 1'b0, 1'b0, 17'd5, 1, 1'b0, 1'b1, 17'd5});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 17'd0, 3, 1'b0, 1'b1, 17'd5});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 17'd0, 4, 1'b0, 1'b1, 17'd4});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 17'd0, 2, 1'b0, 1'b1, 17'd3});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 17'd1, 1, 1'b0, 1'b1, 17'd1});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 17'd0, 3, 1'b0, 1'b1, 17'd1});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 17'd0, 1, 1'b1, 1'b0, 17'd0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 17'd0, 10, 1'b0, 1'b0, 17'd0});
        // Zero delay in periodic mode: pulse at E0, then quiet
        vecs.push_back('{1'b1, 1'b0, 1'b1, 17'd0, 1, 1'b1, 1'b0, 17'd0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 17'd0, 50, 1'b0, 1'b0, 17'd0});
        // Abort wins over a simultaneous start
        vecs.push_back('{1'b1, 1'b1, 1'b0, 17'd4, 1, 1'b0, 1'b0, 17'd0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 17'd0, 40, 1'b0, 1'b0, 17'd0});

        // Reset state
        #12;
        check("reset u4 end", 32'(u4_end), 32'd0);
        check("reset u4 busy", 32'(u4_busy), 32'd0);
        check("reset u4 count", 32'(u4_cnt), 32'd0);
        check("reset u48 busy", 32'(u48_busy), 32'd0);
        @(negedge CLK_I);
        RST_I = 1'b1;

        for (int v = 0; v < vecs.size(); v++) begin
            for (int r = 0; r < vecs[v].reps; r++) begin
                if (r == 0) step4(vecs[v].st, vecs[v].ab, vecs[v].per, vecs[v].dat);
                else        step4(1'b0, 1'b0, 1'b0, 17'd0);
                check($sformatf("vec%0d.%0d end", v, r), 32'(u4_end), 32'(vecs[v].e_end));
                check($sformatf("vec%0d.%0d busy", v, r), 32'(u4_busy), 32'(vecs[v].e_busy));
                check($sformatf("vec%0d.%0d count", v, r), 32'(u4_cnt), 32'(vecs[v].e_cnt));
            end
        end

        // Asynchronous reset between edges during a countdown
        step4(1'b1, 1'b0, 1'b0, 17'd3);
        step4(1'b0, 1'b0, 1'b0, 17'd0);
        step4(1'b0, 1'b0, 1'b0, 17'd0);
        check("pre-reset busy", 32'(u4_busy), 32'd1);
        @(negedge CLK_I);
        #1 RST_I = 1'b0;
        #1;
        check("async rst busy", 32'(u4_busy), 32'd0);
        check("async rst count", 32'(u4_cnt), 32'd0);
        check("async rst end", 32'(u4_end), 32'd0);
        @(posedge CLK_I);
        @(negedge CLK_I);
        RST_I = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step4(1'b0, 1'b0, 1'b0, 17'd0);
            if (u4_end || u4_busy) quiet = 1'b0;
        end
        check("post-reset quiet", 32'(quiet), 32'd1);

        // DIV forced to 1: N=3 expires three edges after start
        step1(1'b1, 17'd3);
        check("div1 start count", 32'(u1_cnt), 32'd3);
        step1(1'b0, 17'd0);
        check("div1 count e1", 32'(u1_cnt), 32'd2);
        step1(1'b0, 17'd0);
        check("div1 count e2", 32'(u1_cnt), 32'd1);
        check("div1 end e2", 32'(u1_end), 32'd0);
        step1(1'b0, 17'd0);
        check("div1 end e3", 32'(u1_end), 32'd1);
        check("div1 busy e3", 32'(u1_busy), 32'd0);
        step1(1'b0, 17'd0);
        check("div1 end e4", 32'(u1_end), 32'd0);

        // Default rates: 100 ticks = 4800 clocks
        step48(1'b1, 1'b0, 17'd100);
        n = 0;
        quiet = 1'b1;
        for (int i = 1; i <= 6000; i++) begin
            step48(1'b0, 1'b0, 17'd0);
            if (u48_end) begin
                n = i;
                break;
            end
            if (!u48_busy) quiet = 1'b0;
        end
        check("default 100us latency", 32'(n), 32'd4800);
        check("default busy until expiry", 32'(quiet), 32'd1);
        check("default busy after expiry", 32'(u48_busy), 32'd0);

        // Full-range load: 100_000 ticks fits the count without truncation
        step48(1'b1, 1'b0, 17'd100_000);
        check("max load count", 32'(u48_cnt), 32'd100_000);
        repeat (48) step48(1'b0, 1'b0, 17'd0);
        check("max first decrement", 32'(u48_cnt), 32'd99_999);
        check("max still busy", 32'(u48_busy), 32'd1);
        step48(1'b0, 1'b1, 17'd0);
        check("max abort busy", 32'(u48_busy), 32'd0);
        check("max abort count", 32'(u48_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lcd_delay_timer.md
Name: lcd_delay_timer

Overview:
Parametrised successor to the single-channel state delay timer used by the HD44780 sequencer. It takes delays in tick units from an internal prescaler rather than raw clocks, so init/command timings (100 ms, 4.1 ms, 100 us, 53 us) are written in microseconds. It adds retrigger, abort, periodic auto-reload, busy and remaining-count outputs. It sits between the LCD controller FSM and the 48 MHz HFOSC clock domain.

Parameters:
SYSFREQ, 48_000_000, CLK_I frequency in Hz.
TICK_HZ, 1_000_000, tick rate; DIV = SYSFREQ/TICK_HZ (integer division), forced to 1 if the result is 0.
COUNT_BITS, 17, width of the tick count; covers 100_000 us.
DIV_BITS, $clog2(DIV)+1, prescaler width (derived; not overridden).

Ports:
CLK_I  in  1  system clock.
RST_I  in  1  reset, asynchronous, active-low.
DAT_I  in  COUNT_BITS  delay in ticks, sampled only on start_strobe.
start_strobe  in  1  one-cycle pulse; loads DAT_I and (re)starts the timer.
abort_strobe  in  1  one-cycle pulse; cancels the timer silently.
periodic  in  1  sampled with start_strobe; 1 = auto-reload mode.
end_strobe  out  1  one-cycle pulse when the delay expires.
busy  out  1  high while a countdown is active.
count_o  out  COUNT_BITS  remaining ticks.

Behaviour:
- Reset (RST_I low, asynchronous): end_strobe=0, busy=0, count_o=0, prescaler=0, reload=0, mode=one-shot. All outputs are registered.
- States: IDLE, RUN. The remaining registers are prescaler (0..DIV-1), count, reload, and mode.
- Priority at each posedge: abort_strobe > start_strobe > countdown.
- abort_strobe: go to IDLE, busy=0, count=0, prescaler=0, end_strobe=0. No end_strobe is emitted. Applies in any state and wins over a simultaneous start.
- start_strobe at edge E0 with DAT_I=N>0: reload<=N, count<=N, prescaler<=0, mode<=periodic, busy<=1, end_strobe<=0, state RUN. This applies in IDLE or RUN; in RUN it retriggers and discards the old countdown with no end_strobe.
- start_strobe with N=0: end_strobe<=1 at E0, busy stays 0, state IDLE. This holds even if periodic=1.
- RUN: prescaler increments each cycle. When prescaler==DIV-1 it wraps to 0 and count decrements.
- Expiry is the decrement from 1 to 0. It occurs at edge E0+N*DIV, where end_strobe<=1 for exactly one cycle.
  - One-shot: busy<=0 at the same edge; count_o=0; state IDLE.
  - Periodic: count<=reload (not 0); busy stays 1; the next end_strobe occurs N*DIV cycles later, indefinitely, until abort or a new start.
- end_strobe is cleared on every cycle in which it is not being set.
- count_o reflects the count register; it is 0 in IDLE.
- DIV=1: count decrements every cycle; end_strobe comes N cycles after start.
- DAT_I and periodic are ignored except at the start_strobe edge.
- Reset during RUN: immediate return to the reset state. No end_strobe is emitted after reset deasserts.

Test Plan:
1. Run with SYSFREQ=4_000_000, TICK_HZ=1_000_000 (DIV=4), start with DAT_I=3, periodic=0 -> end_strobe high for exactly 1 cycle at edge E0+12; busy high for edges E0..E0+11, low from E0+12; count_o steps 3,2,1,0 every 4 cycles.
2. Same configuration, DAT_I=2, periodic=1 -> end_strobe pulses at E0+8, E0+16, E0+24; busy stays 1; count_o reloads to 2 at each pulse. Abort at E0+20 -> no pulse at E0+24; busy=0 and count_o=0 from E0+20.
3. DAT_I=5 started; retrigger at E0+10 with DAT_I=1 -> no pulse at E0+20; a single pulse at E0+14.
4. DAT_I=0 start, periodic=1 -> end_strobe at E0 for 1 cycle; busy never rises; the next 50 cycles are quiet.
5. start_strobe and abort_strobe asserted in the same cycle with DAT_I=4 -> state IDLE, busy=0, no end_strobe within 40 cycles. Separately, assert RST_I low asynchronously mid-count (between edges) -> outputs go to 0 immediately; no pulse after release.
6. Run defaults (48 MHz, 1 MHz tick), DAT_I=100 -> end_strobe exactly 4800 cycles after the start edge. DAT_I=100_000 -> pulse at 4_800_000 cycles, with no count overflow.
